// File: rtl/stream_upsizer_pkg.sv
// Shared definitions for the stream upsizer: FSM encoding and the clog2 helper
// used to size the lane counter.
package stream_upsizer_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_upsizer_if.sv
// Narrow-in / wide-out valid-ready bundle; slave is the upsizer, master drives it.
interface stream_upsizer_if #(
    parameter int DWIDTH = 8,
    parameter int RATIO  = 4
);
    logic [DWIDTH-1:0]       i_data;
    logic                    i_data_last;
    logic                    i_data_valid;
    logic                    o_data_ready;
    logic [RATIO*DWIDTH-1:0] o_data;
    logic [RATIO-1:0]        o_data_keep;
    logic                    o_data_last;
    logic                    o_data_valid;
    logic                    i_data_ready;

    modport slave (
        input  i_data, i_data_last, i_data_valid, i_data_ready,
        output o_data_ready, o_data, o_data_keep, o_data_last, o_data_valid
    );

    modport master (
        output i_data, i_data_last, i_data_valid, i_data_ready,
        input  o_data_ready, o_data, o_data_keep, o_data_last, o_data_valid
    );
endinterface

// File: rtl/stream_upsizer_lane_ctrl.sv
// Tracks which lane the next beat lands in and the keep mask of the word being filled.
module stream_upsizer_lane_ctrl
    import stream_upsizer_pkg::*;
#(
    parameter int RATIO = 4,
    localparam int CW   = clog2(RATIO)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             in_fire_i,
    input  logic             last_i,
    output logic [CW-1:0]    lane_cnt_o,
    output logic [RATIO-1:0] keep_close_o,
    output logic             close_o
);

    logic [CW-1:0]    lane_cnt_q, lane_cnt_d;
    logic [RATIO-1:0] keep_q, keep_d;

    assign close_o      = (lane_cnt_q == CW'(RATIO - 1)) | last_i;
    assign keep_close_o = keep_q | (RATIO'(1) << lane_cnt_q);
    assign lane_cnt_o   = lane_cnt_q;

    always_comb begin
        lane_cnt_d = lane_cnt_q;
        keep_d     = keep_q;
        if (in_fire_i) begin
            if (close_o) begin
                lane_cnt_d = '0;
                keep_d     = '0;
            end else begin
                lane_cnt_d = lane_cnt_q + CW'(1);
                keep_d     = keep_close_o;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            lane_cnt_q <= '0;
            keep_q     <= '0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            keep_q     <= keep_d;
        end
    end

endmodule

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow beats into one registered wide word; a last beat closes the word early.
// state | meaning
// EMPTY | no output word held, o_data_valid=0
// FULL  | output word held, o_data_valid=1 until downstream takes it
module stream_upsizer
    import stream_upsizer_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int RATIO  = 4
) (
    input  logic            i_clock,
    input  logic            i_reset,
    stream_upsizer_if.slave bus
);

    localparam int CW = clog2(RATIO);

    generate
        if (RATIO < 2 || RATIO > 16) begin : g_ratio_check
            $error("stream_upsizer: RATIO must be within 2..16");
        end
    endgenerate

    state_e                        state_q, state_d;
    logic [RATIO-1:0][DWIDTH-1:0]  fill_q, fill_d, word_close;
    logic [RATIO*DWIDTH-1:0]       data_q, data_d;
    logic [RATIO-1:0]              keep_q, keep_d;
    logic                          last_q, last_d;

    logic                          ready, in_fire, out_fire, close;
    logic [CW-1:0]                 lane_cnt;
    logic [RATIO-1:0]              keep_close;

    // Ready looks through to downstream so a drained word can be refilled in the same cycle.
    assign ready    = (state_q == EMPTY) | bus.i_data_ready;
    assign in_fire  = bus.i_data_valid & ready;
    assign out_fire = (state_q == FULL) & bus.i_data_ready;

    stream_upsizer_lane_ctrl #(.RATIO(RATIO)) u_lane_ctrl (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .in_fire_i    (in_fire),
        .last_i       (bus.i_data_last),
        .lane_cnt_o   (lane_cnt),
        .keep_close_o (keep_close),
        .close_o      (close)
    );

    always_comb begin
        word_close           = fill_q;
        word_close[lane_cnt] = bus.i_data;
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;

        if (in_fire) begin
            if (close) begin
                fill_d = '0;
                data_d = word_close;
                keep_d = keep_close;
                last_d = bus.i_data_last;
            end else begin
                fill_d = word_close;
            end
        end

        case (state_q)
            EMPTY: if (in_fire && close) state_d = FULL;
            FULL:  if (out_fire) state_d = (in_fire && close) ? FULL : EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= EMPTY;
            fill_q  <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign bus.o_data_ready = ready;
    assign bus.o_data       = data_q;
    assign bus.o_data_keep  = keep_q;
    assign bus.o_data_last  = last_q;
    assign bus.o_data_valid = (state_q == FULL);

endmodule

// File: tb/tb_stream_upsizer.sv
// Bench for stream_upsizer: directed cases with literal expectations plus a
// randomized run, all continuously compared against a queue-based packing model.
module tb_stream_upsizer;

    localparam int DW = 8;
    localparam int R  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_upsizer_if #(.DWIDTH(DW), .RATIO(R)) bus ();

    stream_upsizer #(.DWIDTH(DW), .RATIO(R)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: beats accumulate in a queue; a word forms when the queue
    // holds R beats or a last beat arrives, and is held until downstream takes it.
    logic            m_valid = 1'b0;
    logic [R*DW-1:0] m_word  = '0;
    logic [R-1:0]    m_keep  = '0;
    logic            m_last  = 1'b0;
    logic [DW-1:0]   cur[$];
    int              words_model = 0;
    int              words_dut   = 0;
    logic            armed = 1'b0;

    always @(negedge clk) begin : monitor
        logic fin, fout;
        if (armed) begin
            check("ready", bus.o_data_ready, !m_valid || bus.i_data_ready);
            check("valid", bus.o_data_valid, m_valid);
            if (m_valid) begin
                check("data", bus.o_data, m_word);
                check("keep", bus.o_data_keep, m_keep);
                check("last", bus.o_data_last, m_last);
            end
            if (bus.o_data_valid && bus.i_data_ready) words_dut++;
        end
        if (rst) begin
            m_valid = 1'b0;
            cur.delete();
            armed = 1'b1;
        end else if (armed) begin
            fout = m_valid && bus.i_data_ready;
            fin  = bus.i_data_valid && (!m_valid || bus.i_data_ready);
            if (fout) begin
                m_valid = 1'b0;
                words_model++;
            end
            if (fin) begin
                cur.push_back(bus.i_data);
                if (cur.size() == R || bus.i_data_last) begin
                    m_word = '0;
                    foreach (cur[k]) m_word |= (R*DW)'(cur[k]) << (DW * k);
                    m_keep  = R'((1 << cur.size()) - 1);
                    m_last  = bus.i_data_last;
                    m_valid = 1'b1;
                    cur.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic l);
        bus.i_data       = d;
        bus.i_data_last  = l;
        bus.i_data_valid = 1'b1;
        tick();
    endtask

    task automatic idle();
        bus.i_data_valid = 1'b0;
        bus.i_data_last  = 1'b0;
    endtask

    task automatic check_word(input string name, input logic [31:0] d, input logic [3:0] k, input logic l);
        check({name, "_valid"}, bus.o_data_valid, 1'b1);
        check({name, "_data"},  bus.o_data, d);
        check({name, "_keep"},  bus.o_data_keep, k);
        check({name, "_last"},  bus.o_data_last, l);
    endtask

    logic [31:0] t2_words [3] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};

    initial begin
        bus.i_data       = '0;
        bus.i_data_last  = 1'b0;
        bus.i_data_valid = 1'b0;
        bus.i_data_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        check("rst_valid", bus.o_data_valid, 1'b0);
        check("rst_data",  bus.o_data, 32'h0);
        check("rst_keep",  bus.o_data_keep, 4'h0);
        check("rst_last",  bus.o_data_last, 1'b0);
        rst = 1'b0;

        // 1: one full word, valid exactly one cycle after the 4th beat
        drive(8'h11, 1'b0);
        drive(8'h22, 1'b0);
        drive(8'h33, 1'b0);
        check("t1_early_valid", bus.o_data_valid, 1'b0);
        drive(8'h44, 1'b0);
        check_word("t1", 32'h44332211, 4'hF, 1'b0);
        idle();
        tick();
        check("t1_drained", bus.o_data_valid, 1'b0);

        // 2: continuous stream, no bubbles
        for (int i = 1; i <= 12; i++) begin
            drive(DW'(i), 1'b0);
            check("t2_ready", bus.o_data_ready, 1'b1);
            if (i % 4 == 0) check("t2_word", bus.o_data, t2_words[i/4-1]);
        end
        idle();
        tick();

        // 3: early close, then a single-beat packet in lane 0
        drive(8'hA1, 1'b0);
        drive(8'hA2, 1'b1);
        check_word("t3", 32'h0000A2A1, 4'h3, 1'b1);
        drive(8'hB1, 1'b1);
        check_word("t3_single", 32'h000000B1, 4'h1, 1'b1);
        idle();
        tick();

        // 4: downstream stall holds the word and blocks upstream
        drive(8'hC1, 1'b0);
        drive(8'hC2, 1'b0);
        drive(8'hC3, 1'b0);
        bus.i_data_ready = 1'b0;
        drive(8'hC4, 1'b0);
        bus.i_data       = 8'hD1;
        bus.i_data_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4_stall_ready", bus.o_data_ready, 1'b0);
            tick();
            check_word("t4_hold", 32'hC4C3C2C1, 4'hF, 1'b0);
        end
        bus.i_data_ready = 1'b1;
        #1;
        check("t4_release_ready", bus.o_data_ready, 1'b1);
        tick();
        check("t4_after_release", bus.o_data_valid, 1'b0);
        drive(8'hD2, 1'b0);
        drive(8'hD3, 1'b0);
        drive(8'hD4, 1'b0);
        check_word("t4_next", 32'hD4D3D2D1, 4'hF, 1'b0);
        idle();
        tick();

        // 5: reset mid-packet discards the partial word
        drive(8'h91, 1'b0);
        drive(8'h92, 1'b0);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valid", bus.o_data_valid, 1'b0);
        check("t5_data",  bus.o_data, 32'h0);
        check("t5_keep",  bus.o_data_keep, 4'h0);
        check("t5_last",  bus.o_data_last, 1'b0);
        drive(8'h55, 1'b0);
        drive(8'h56, 1'b0);
        drive(8'h57, 1'b0);
        drive(8'h58, 1'b0);
        check_word("t5", 32'h58575655, 4'hF, 1'b0);
        idle();
        tick();

        // 6: random valid/ready/last
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.i_data       = DW'($urandom);
            bus.i_data_valid = ($urandom_range(0, 9) < 7);
            bus.i_data_last  = ($urandom_range(0, 7) == 0);
            bus.i_data_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        idle();
        bus.i_data_ready = 1'b1;
        tick();
        tick();
        tick();
        check("word_count", 64'(words_dut), 64'(words_model));
        check("final_idle", bus.o_data_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
